// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the shift-add multiplier controller
package mult_pkg;

  localparam int MULT_WIDTH          = 12;
  localparam int MULT_CNT_W          = 4;
  localparam int MULT_TIMEOUT_CYCLES = 64;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START_IN  = 4'd1;
  localparam logic [3:0] ST_WAIT_IN   = 4'd2;
  localparam logic [3:0] ST_LOAD      = 4'd3;
  localparam logic [3:0] ST_TEST      = 4'd4;
  localparam logic [3:0] ST_ADD       = 4'd5;
  localparam logic [3:0] ST_SHIFT     = 4'd6;
  localparam logic [3:0] ST_START_OUT = 4'd7;
  localparam logic [3:0] ST_WAIT_OUT  = 4'd8;
  localparam logic [3:0] ST_DONE      = 4'd9;
  localparam logic [3:0] ST_ERR       = 4'd10;

  // States in which the controller waits on an external handshake flag
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == ST_WAIT_IN) || (s == ST_WAIT_OUT);
  endfunction

endpackage

// File: rtl/mult_ctrl_watchdog.sv
// rtl/mult_ctrl_watchdog.sv - cycle counter that flags a stalled handshake wait
module mult_ctrl_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles; a state change restarts the count from zero
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is seen in the LIMIT-th waiting cycle so the FSM leaves exactly LIMIT cycles after entry
  assign o_expired = i_en && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - sequencer for the shift-add multiplier (optional watchdog: MULT_CTRL_TIMEOUT_EN)
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
`ifdef MULT_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = MULT_TIMEOUT_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sx,
  input  logic             fx_x,
  input  logic             fx_y,
  output logic             ld,
  input  logic             m0,
  output logic             add_en,
  output logic             shift_en,
  output logic             sz,
  input  logic             fz,
  output logic [CNT_W-1:0] iter,
  output logic             err
);

  logic [3:0]       r_state;
  logic [3:0]       w_state_next;
  logic             r_settled;
  logic [CNT_W-1:0] r_iter;
  logic             w_last;
  logic             w_expired;

  assign w_last = (r_iter == CNT_W'(WIDTH - 1));

`ifdef MULT_CTRL_TIMEOUT_EN
  mult_ctrl_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_state_next != r_state),
    .i_en     (is_wait_state(r_state)),
    .o_expired(w_expired)
  );

  assign err = (r_state == ST_ERR);
`else
  assign w_expired = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state decode; wait states ignore their flags until r_settled marks the first cycle as past
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_START_IN;
      ST_START_IN:  w_state_next = ST_WAIT_IN;
      ST_WAIT_IN: begin
        if (w_expired)                       w_state_next = ST_ERR;
        else if (r_settled && fx_x && fx_y)  w_state_next = ST_LOAD;
      end
      ST_LOAD:      w_state_next = ST_TEST;
      ST_TEST:      w_state_next = m0 ? ST_ADD : ST_SHIFT;
      ST_ADD:       w_state_next = ST_SHIFT;
      ST_SHIFT:     w_state_next = w_last ? ST_START_OUT : ST_TEST;
      ST_START_OUT: w_state_next = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        if (w_expired)            w_state_next = ST_ERR;
        else if (r_settled && fz) w_state_next = ST_DONE;
      end
      ST_DONE:      w_state_next = ST_IDLE;
`ifdef MULT_CTRL_TIMEOUT_EN
      ST_ERR:       w_state_next = ST_ERR;
`endif
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Low only in the first cycle after a state change, which masks stale done flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settled <= 1'b0;
    end else begin
      r_settled <= (w_state_next == r_state);
    end
  end

  // Iteration counter: cleared on load, bumped on each shift, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iter <= '0;
    end else if (r_state == ST_LOAD) begin
      r_iter <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_iter <= r_iter + 1'b1;
    end
  end

  assign iter     = r_iter;
  assign busy     = (r_state != ST_IDLE);
  assign sx       = (r_state == ST_START_IN);
  assign ld       = (r_state == ST_LOAD);
  assign add_en   = (r_state == ST_ADD);
  assign shift_en = (r_state == ST_SHIFT);
  assign sz       = (r_state == ST_START_OUT);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_mult_controller.sv
// tb/tb_mult_controller.sv - self-checking bench for mult_controller with a result scoreboard
module tb_mult_controller;

  localparam int WIDTH = 12;

  typedef struct {
    int adds;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       fx_x = 1'b1;
  logic       fx_y = 1'b1;
  logic       fz = 1'b1;
  logic       m0;
  logic       busy, done, sx, ld, add_en, shift_en, sz, err;
  logic [3:0] iter;

  logic [11:0] r_mult = '0;
  logic [11:0] r_mreg = '0;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ld_cyc = 0;
  int   sz_cyc = 0;
  int   n_add = 0;
  int   n_shift = 0;
  int   n_done = 0;
  int   exp_done = 0;
  bit   prev_add = 0;

  mult_controller dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .sx      (sx),
    .fx_x    (fx_x),
    .fx_y    (fx_y),
    .ld      (ld),
    .m0      (m0),
    .add_en  (add_en),
    .shift_en(shift_en),
    .sz      (sz),
    .fz      (fz),
    .iter    (iter),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Multiplier register of the datapath: loaded on ld, shifted right on shift_en
  always @(posedge clk) begin
    cyc++;
    if (ld) r_mreg <= r_mult;
    else if (shift_en) r_mreg <= r_mreg >> 1;
  end
  assign m0 = r_mreg[0];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor and scoreboard pop on every done
  always @(negedge clk) begin : mon
    if (reset) begin
      prev_add = 0;
    end else begin
      if (add_en) check("add_shift_exclusive", shift_en, 0);
      if (prev_add) check("add_then_shift", shift_en, 1);
      prev_add = add_en;
      if (ld) begin
        ld_cyc  = cyc;
        n_add   = 0;
        n_shift = 0;
      end
      if (add_en) n_add++;
      if (shift_en) n_shift++;
      if (sz) sz_cyc = cyc;
      if (done) begin
        n_done++;
        check("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("add_pulses", n_add, mon_e.adds);
          check("shift_pulses", n_shift, WIDTH);
          check("compute_latency", sz_cyc - ld_cyc, mon_e.lat);
          check("iter_final", int'(iter), WIDTH);
        end
      end
    end
  end

  task automatic launch(input logic [11:0] mult, input int skew);
    exp_t e;
    r_mult = mult;
    e.adds = $countones(mult);
    e.lat  = 1 + 2 * WIDTH + e.adds;
    sb.push_back(e);
    fx_x  = 1'b1;
    fx_y  = 1'b1;
    fz    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sx_pulse", sx, 1);
    check("busy_started", busy, 1);
    @(negedge clk);
    check("sx_one_cycle", sx, 0);
    @(negedge clk);
    check("ld_masked_stale", ld, 0);
    fx_x = 1'b0;
    fx_y = 1'b0;
    repeat (2) @(negedge clk);
    fx_x = 1'b1;
    repeat (skew) begin
      @(negedge clk);
      check("ld_wait_fy", ld, 0);
    end
    fx_y = 1'b1;
    @(negedge clk);
    check("ld_after_fy", ld, 1);
  endtask

  task automatic wait_sz(input bit poke);
    int k = 0;
    while (!sz && k < 200) begin
      @(negedge clk);
      k++;
      start = poke && (k == 5);
    end
    start = 1'b0;
    check("sz_reached", sz, 1);
  endtask

  task automatic finish_op(input bit start_at_done);
    @(negedge clk);
    check("sz_one_cycle", sz, 0);
    @(negedge clk);
    check("done_masked_stale", done, 0);
    fz = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("done_wait_fz", done, 0);
    end
    fz = 1'b1;
    @(negedge clk);
    check("done_after_fz", done, 1);
    exp_done++;
    start = start_at_done;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    @(negedge clk);
    check("no_relaunch", busy, 0);
  endtask

  task automatic run_op(input logic [11:0] mult, input int skew, input bit poke, input bit start_at_done);
    launch(mult, skew);
    wait_sz(poke);
    finish_op(start_at_done);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sx", sx, 0);
    check("rst_ld", ld, 0);
    check("rst_add_en", add_en, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_sz", sz, 0);
    check("rst_err", err, 0);
    check("rst_iter", int'(iter), 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(12'd5,   0, 0, 0);
    run_op(12'd0,   1, 0, 0);
    run_op(12'hFFF, 3, 1, 1);
    run_op(12'hA53, 2, 0, 0);
    check("iter_held_idle", int'(iter), WIDTH);
    check("done_count", n_done, exp_done);

    launch(12'h0F0, 1);
    k = 0;
    while (!(shift_en && iter == 4'd7) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abort_at_iter7", int'(iter), 7);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_iter", int'(iter), 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    void'(sb.pop_back());
    repeat (4) begin
      @(negedge clk);
      check("abort_quiet", {busy, done}, 0);
    end
    check("done_count_abort", n_done, exp_done);

    run_op(12'h800, 0, 0, 0);
    check("done_count_final", n_done, exp_done);

`ifdef MULT_CTRL_TIMEOUT_EN
    launch(12'h003, 0);
    wait_sz(0);
    fz = 1'b0;
    k = 0;
    while (!err && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("err_delay", k, 65);
    repeat (5) begin
      @(negedge clk);
      check("err_sticky", err, 1);
      check("err_busy", busy, 1);
      check("err_no_done", done, 0);
    end
    void'(sb.pop_back());
    reset = 1'b1;
    @(negedge clk);
    check("err_cleared", err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("done_count_err", n_done, exp_done);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
